ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 34 +++
 rtl/ex_alu.sv | 30 +++
 rtl/ex_stage.sv | 113 +++++++++++
 tb/tb_ex_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
// ALUOp encodings, 3-bit ALU-control/funct codes and control-bus bit indices.
package ex_pkg;

    // ALUOp field of the EX control bus
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // 2'b11 also decodes funct

    // ALU control codes; identical to the 3-bit funct encoding so funct maps straight through
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_e;

    // EX control bus bit positions
    localparam int EX_ALUSRC  = 3;
    localparam int EX_ALUOP_H = 2;
    localparam int EX_ALUOP_L = 1;
    localparam int EX_REGDST  = 0;

    // MEM and WB control bus bit positions (passed through untouched here)
    localparam int MEM_WRITE   = 1;
    localparam int MEM_READ    = 0;
    localparam int WB_MEMTOREG = 1;
    localparam int WB_REGWRITE = 0;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: purely combinational 32-bit ALU with a result-is-zero flag.
// ADD/SUB wrap modulo 2^32; SLT is a signed compare; SLL shifts by b[4:0].
import ex_pkg::*;

module ex_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_ctl_e    op,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select and zero detect
    always_comb begin
        result = 32'd0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLL: result = a << b[4:0];
            ALU_SUB: result = a - b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: result = 32'd0;
        endcase
        zero = (result == 32'd0);
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage pipeline. Operand/destination muxes,
// ALU control decode, and the EX/MEM pipeline register (1-cycle latency).
// There is no handshake: a new instruction is accepted on every rising edge.
// Optional feature macro: EX_ZERO_FLAG_EN adds a registered Out_Zero output.
import ex_pkg::*;

module ex_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] In_DataA,
    input  logic [31:0] In_DataB,
    input  logic [31:0] In_SE,
    input  logic [4:0]  In_Rt,
    input  logic [4:0]  In_Rd,
    input  logic [3:0]  In_EXControl,
    input  logic [1:0]  In_MEMControl,
    input  logic [1:0]  In_WBControl,
    input  logic [2:0]  In_Funct,
    output logic [31:0] Out_Result,
    output logic [31:0] Out_Data,
    output logic [4:0]  Out_Rd,
    output logic [1:0]  Out_MEMControl,
    output logic [1:0]  Out_WBControl
`ifdef EX_ZERO_FLAG_EN
    ,
    output logic        Out_Zero
`endif
);

    logic [31:0] alu_b;
    alu_ctl_e    alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;

    logic [31:0] result_d, result_q;
    logic [31:0] data_d,   data_q;
    logic [4:0]  rd_d,     rd_q;
    logic [1:0]  mem_d,    mem_q;
    logic [1:0]  wb_d,     wb_q;

    // Operand B mux and ALU control decode from ALUOp / funct
    always_comb begin
        alu_b  = In_EXControl[EX_ALUSRC] ? In_SE : In_DataB;
        alu_op = ALU_ADD;
        case (In_EXControl[EX_ALUOP_H:EX_ALUOP_L])
            ALUOP_ADD: alu_op = ALU_ADD;
            ALUOP_SUB: alu_op = ALU_SUB;
            default:   alu_op = alu_ctl_e'(In_Funct);
        endcase
    end

    ex_alu u_alu (
        .a      (In_DataA),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Next values of the EX/MEM register; store data is always rt, never the immediate
    always_comb begin
        result_d = alu_result;
        data_d   = In_DataB;
        rd_d     = In_EXControl[EX_REGDST] ? In_Rd : In_Rt;
        mem_d    = In_MEMControl;
        wb_d     = In_WBControl;
    end

    // EX/MEM pipeline register; reset discards the instruction presented this cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            result_q <= 32'd0;
            data_q   <= 32'd0;
            rd_q     <= 5'd0;
            mem_q    <= 2'd0;
            wb_q     <= 2'd0;
        end else begin
            result_q <= result_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
        end
    end

    assign Out_Result     = result_q;
    assign Out_Data       = data_q;
    assign Out_Rd         = rd_q;
    assign Out_MEMControl = mem_q;
    assign Out_WBControl  = wb_q;

`ifdef EX_ZERO_FLAG_EN
    logic zero_d, zero_q;

    // Zero flag travels with its result
    always_comb begin
        zero_d = alu_zero;
    end

    // Zero flag register
    always_ff @(posedge Clk) begin
        if (Rst) zero_q <= 1'b0;
        else     zero_q <= zero_d;
    end

    assign Out_Zero = zero_q;
`else
    // Zero flag is not exported in this build
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven vectors plus random stream for ex_stage.
// Expected outputs are queued when inputs are driven and compared one edge later.
module tb_ex_stage;

    localparam int W = 74;  // {result32, data32, rd5, mem2, wb2, zero1}

    logic        Clk;
    logic        Rst;
    logic [31:0] In_DataA, In_DataB, In_SE;
    logic [4:0]  In_Rt, In_Rd;
    logic [3:0]  In_EXControl;
    logic [1:0]  In_MEMControl, In_WBControl;
    logic [2:0]  In_Funct;
    logic [31:0] Out_Result, Out_Data;
    logic [4:0]  Out_Rd;
    logic [1:0]  Out_MEMControl, Out_WBControl;
`ifdef EX_ZERO_FLAG_EN
    logic        Out_Zero;
`endif

    ex_stage dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .In_DataA       (In_DataA),
        .In_DataB       (In_DataB),
        .In_SE          (In_SE),
        .In_Rt          (In_Rt),
        .In_Rd          (In_Rd),
        .In_EXControl   (In_EXControl),
        .In_MEMControl  (In_MEMControl),
        .In_WBControl   (In_WBControl),
        .In_Funct       (In_Funct),
        .Out_Result     (Out_Result),
        .Out_Data       (Out_Data),
        .Out_Rd         (Out_Rd),
        .Out_MEMControl (Out_MEMControl),
        .Out_WBControl  (Out_WBControl)
`ifdef EX_ZERO_FLAG_EN
        ,
        .Out_Zero       (Out_Zero)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] a, b, se;
        logic [4:0]  rt, rd;
        logic [3:0]  ex;
        logic [1:0]  mem, wb;
        logic [2:0]  funct;
        logic [31:0] e_res, e_data;
        logic [4:0]  e_rd;
        logic [1:0]  e_mem, e_wb;
        logic        e_zero;
    } vec_t;

    vec_t tbl[14];

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(
        input logic [31:0] a, b, se, input logic [4:0] rt, rd, input logic [3:0] ex,
        input logic [1:0] mem, wb, input logic [2:0] funct,
        input logic [31:0] e_res, e_data, input logic [4:0] e_rd,
        input logic [1:0] e_mem, e_wb, input logic e_zero);
        vec_t v;
        v.a = a; v.b = b; v.se = se; v.rt = rt; v.rd = rd; v.ex = ex;
        v.mem = mem; v.wb = wb; v.funct = funct;
        v.e_res = e_res; v.e_data = e_data; v.e_rd = e_rd;
        v.e_mem = e_mem; v.e_wb = e_wb; v.e_zero = e_zero;
        return v;
    endfunction

    function automatic logic [W-1:0] pack_exp(input vec_t v);
        return {v.e_res, v.e_data, v.e_rd, v.e_mem, v.e_wb, v.e_zero};
    endfunction

    // Reference model written from the instruction semantics
    function automatic logic [W-1:0] model(input vec_t v);
        logic [31:0] opb, r;
        logic [2:0]  f;
        opb = v.ex[3] ? v.se : v.b;
        if (v.ex[2:1] == 2'b00)      f = 3'b010;
        else if (v.ex[2:1] == 2'b01) f = 3'b110;
        else                         f = v.funct;
        unique case (f)
            3'b000: r = v.a & opb;
            3'b001: r = v.a | opb;
            3'b010: r = v.a + opb;
            3'b011: r = v.a ^ opb;
            3'b100: r = ~(v.a | opb);
            3'b101: r = v.a << opb[4:0];
            3'b110: r = v.a - opb;
            default: r = ($signed(v.a) < $signed(opb)) ? 32'd1 : 32'd0;
        endcase
        return {r, v.b, (v.ex[0] ? v.rd : v.rt), v.mem, v.wb, (r == 32'd0)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_out();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: output observed with empty expected queue");
            return;
        end
        e = exp_q.pop_front();
        chk("result", Out_Result,             e[73:42]);
        chk("data",   Out_Data,               e[41:10]);
        chk("rd",     {27'd0, Out_Rd},         {27'd0, e[9:5]});
        chk("mem",    {30'd0, Out_MEMControl}, {30'd0, e[4:3]});
        chk("wb",     {30'd0, Out_WBControl},  {30'd0, e[2:1]});
`ifdef EX_ZERO_FLAG_EN
        chk("zero",   {31'd0, Out_Zero},       {31'd0, e[0]});
`endif
    endtask

    // ---------------- driver ----------------
    // Present one instruction before an edge; the scoreboard checks it just after that edge.
    task automatic drive(input vec_t v, input logic rst, input logic [W-1:0] exp);
        @(negedge Clk);
        In_DataA = v.a; In_DataB = v.b; In_SE = v.se;
        In_Rt = v.rt; In_Rd = v.rd; In_EXControl = v.ex;
        In_MEMControl = v.mem; In_WBControl = v.wb; In_Funct = v.funct;
        Rst = rst;
        exp_q.push_back(rst ? '0 : exp);
        @(posedge Clk);
        #1;
        check_out();
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t rv;
        Rst = 1'b1;
        In_DataA = '0; In_DataB = '0; In_SE = '0; In_Rt = '0; In_Rd = '0;
        In_EXControl = '0; In_MEMControl = '0; In_WBControl = '0; In_Funct = '0;

        //            a             b             se            rt     rd     ex       mem    wb     funct   e_res         e_data        e_rd   e_mem  e_wb   e_zero
        tbl[0]  = mk(32'd4,        32'd8,        32'hFFFFFFFF, 5'd8,  5'd9,  4'b1101, 2'b00, 2'b11, 3'b010, 32'd3,        32'd8,        5'd9,  2'b00, 2'b11, 1'b0);
        tbl[1]  = mk(32'd10,       32'd3,        32'd0,        5'd5,  5'd7,  4'b0100, 2'b00, 2'b01, 3'b110, 32'd7,        32'd3,        5'd5,  2'b00, 2'b01, 1'b0);
        tbl[2]  = mk(32'h80000000, 32'd1,        32'd0,        5'd1,  5'd2,  4'b0101, 2'b00, 2'b01, 3'b111, 32'd1,        32'd1,        5'd2,  2'b00, 2'b01, 1'b0);
        tbl[3]  = mk(32'h7FFFFFFF, 32'd1,        32'd0,        5'd1,  5'd2,  4'b0101, 2'b00, 2'b01, 3'b010, 32'h80000000, 32'd1,        5'd2,  2'b00, 2'b01, 1'b0);
        tbl[4]  = mk(32'h100,      32'h55,       32'h10,       5'd12, 5'd13, 4'b1000, 2'b01, 2'b11, 3'b000, 32'h110,      32'h55,       5'd12, 2'b01, 2'b11, 1'b0);
        tbl[5]  = mk(32'd5,        32'd5,        32'd0,        5'd0,  5'd0,  4'b0010, 2'b00, 2'b00, 3'b000, 32'd0,        32'd5,        5'd0,  2'b00, 2'b00, 1'b1);
        tbl[6]  = mk(32'hF0F01234, 32'h0FF0FF00, 32'd0,        5'd3,  5'd4,  4'b0100, 2'b10, 2'b01, 3'b000, 32'h00F01200, 32'h0FF0FF00, 5'd3,  2'b10, 2'b01, 1'b0);
        tbl[7]  = mk(32'hF0F01234, 32'h0FF0FF00, 32'd0,        5'd3,  5'd4,  4'b0110, 2'b00, 2'b01, 3'b001, 32'hFFF0FF34, 32'h0FF0FF00, 5'd3,  2'b00, 2'b01, 1'b0);
        tbl[8]  = mk(32'hF0F01234, 32'h0FF0FF00, 32'd0,        5'd3,  5'd4,  4'b0101, 2'b00, 2'b01, 3'b011, 32'hFF00ED34, 32'h0FF0FF00, 5'd4,  2'b00, 2'b01, 1'b0);
        tbl[9]  = mk(32'hF0F01234, 32'h0FF0FF00, 32'd0,        5'd3,  5'd4,  4'b0101, 2'b00, 2'b01, 3'b100, 32'h000F00CB, 32'h0FF0FF00, 5'd4,  2'b00, 2'b01, 1'b0);
        tbl[10] = mk(32'd3,        32'h24,       32'd0,        5'd6,  5'd17, 4'b0101, 2'b00, 2'b01, 3'b101, 32'h30,       32'h24,       5'd17, 2'b00, 2'b01, 1'b0);
        tbl[11] = mk(32'd5,        32'hFFFFFFFF, 32'd0,        5'd6,  5'd17, 4'b0111, 2'b00, 2'b01, 3'b111, 32'd0,        32'hFFFFFFFF, 5'd17, 2'b00, 2'b01, 1'b1);
        tbl[12] = mk(32'd0,        32'd1,        32'd0,        5'd31, 5'd30, 4'b0010, 2'b00, 2'b00, 3'b000, 32'hFFFFFFFF, 32'd1,        5'd31, 2'b00, 2'b00, 1'b0);
        tbl[13] = mk(32'h1234,     32'hABCD,     32'hFFFFFFF0, 5'd9,  5'd10, 4'b1010, 2'b10, 2'b00, 3'b000, 32'h1244,     32'hABCD,     5'd9,  2'b10, 2'b00, 1'b0);

        // Reset with nonzero inputs overrides them, then the first edge out of reset captures
        drive(tbl[0], 1'b1, pack_exp(tbl[0]));
        drive(tbl[0], 1'b0, pack_exp(tbl[0]));

        // Table, streamed back to back
        for (int i = 0; i < 14; i++) drive(tbl[i], 1'b0, pack_exp(tbl[i]));

        // Mid-stream reset drops the instruction in flight; the next one flows normally
        drive(tbl[6], 1'b0, pack_exp(tbl[6]));
        drive(tbl[7], 1'b1, pack_exp(tbl[7]));
        drive(tbl[8], 1'b0, pack_exp(tbl[8]));

        // Random stream with occasional reset
        for (int i = 0; i < 60; i++) begin
            rv = tbl[0];
            rv.a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            rv.b  = ($urandom_range(0, 3) == 0) ? rv.a : $urandom;
            rv.se = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
            rv.rt = 5'($urandom_range(0, 31));
            rv.rd = 5'($urandom_range(0, 31));
            rv.ex = 4'($urandom_range(0, 15));
            rv.mem = 2'($urandom_range(0, 3));
            rv.wb  = 2'($urandom_range(0, 3));
            rv.funct = 3'($urandom_range(0, 7));
            drive(rv, ($urandom_range(0, 9) == 0), model(rv));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
